// File: rtl/valid_ready_pkg.sv
// Shared types and constants for the valid/ready pipeline slice.
//   slice_mode_e : implementation selected by the MODE parameter
//   skid_state_e : occupancy of the skid-buffer implementation
//   BEATS_W      : width of the optional downstream beat counter
package valid_ready_pkg;

    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_FWD    = 2'd1,
        SLICE_SKID   = 2'd2
    } slice_mode_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    localparam int BEATS_W = 16;

endpackage

// File: rtl/valid_ready_skid.sv
// Full-throughput skid buffer: a main output register plus one skid register.
// up_ready comes straight from a flop, so nothing from dn_ready reaches the upstream side
// combinationally.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   up_valid/up_data   upstream payload, up_ready back to the producer
//   dn_valid/dn_data   downstream payload, dn_ready from the consumer
module valid_ready_skid
    import valid_ready_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             up_ready,
    output logic             dn_valid,
    output logic [WIDTH-1:0] dn_data,
    input  logic             dn_ready
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             ready_q;
    logic             up_fire;
    logic             dn_fire;

    assign up_fire  = up_valid && ready_q;
    assign dn_fire  = (state_q != EMPTY) && dn_ready;
    assign up_ready = ready_q;
    assign dn_valid = (state_q != EMPTY);
    assign dn_data  = main_q;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (up_fire) begin
                    state_d = BUSY;
                    main_d  = up_data;
                end
            end
            BUSY: begin
                if (up_fire && dn_fire) begin
                    main_d = up_data;
                end else if (up_fire) begin
                    // Consumer stalled while a new beat arrived: park it in the skid slot.
                    state_d = FULL;
                    skid_d  = up_data;
                end else if (dn_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (dn_fire) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            // Registered ready: accept whenever the skid slot will be free next cycle.
            ready_q <= (state_d != FULL);
        end
    end

endmodule

// File: rtl/valid_ready_slice.sv
// Configurable valid/ready pipeline slice between an upstream producer and a consumer.
// MODE picks the implementation at elaboration:
//   0 = combinational bypass, 1 = forward register, 2 = skid buffer (valid_ready_skid).
// Optional macro VALID_READY_SLICE_BEATS_EN adds o_beats, a wrapping count of downstream
// transfers.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_up_valid, i_up_data    upstream payload; o_up_ready back to the producer
//   o_dn_valid, o_dn_data    downstream payload; i_dn_ready from the consumer
//   o_beats                  downstream transfer count (only with VALID_READY_SLICE_BEATS_EN)
module valid_ready_slice
    import valid_ready_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_up_valid,
    input  logic [WIDTH-1:0]   i_up_data,
    output logic               o_up_ready,
    output logic               o_dn_valid,
    output logic [WIDTH-1:0]   o_dn_data,
    input  logic               i_dn_ready
`ifdef VALID_READY_SLICE_BEATS_EN
    ,
    output logic [BEATS_W-1:0] o_beats
`endif
);

    if (MODE == int'(SLICE_BYPASS)) begin : g_bypass
        assign o_dn_valid = i_up_valid;
        assign o_dn_data  = i_up_data;
        assign o_up_ready = i_dn_ready;
    end else if (MODE == int'(SLICE_FWD)) begin : g_fwd
        logic             fwd_valid_q;
        logic [WIDTH-1:0] fwd_data_q;

        // The register can take a beat if it is empty or being drained this cycle.
        assign o_up_ready = !fwd_valid_q || i_dn_ready;
        assign o_dn_valid = fwd_valid_q;
        assign o_dn_data  = fwd_data_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                fwd_valid_q <= 1'b0;
                fwd_data_q  <= '0;
            end else if (o_up_ready) begin
                fwd_valid_q <= i_up_valid;
                if (i_up_valid) begin
                    fwd_data_q <= i_up_data;
                end
            end
        end
    end else if (MODE == int'(SLICE_SKID)) begin : g_skid
        valid_ready_skid #(
            .WIDTH (WIDTH)
        ) u_skid (
            .clk      (clk),
            .rst      (rst),
            .up_valid (i_up_valid),
            .up_data  (i_up_data),
            .up_ready (o_up_ready),
            .dn_valid (o_dn_valid),
            .dn_data  (o_dn_data),
            .dn_ready (i_dn_ready)
        );
    end else begin : g_bad_mode
        $error("valid_ready_slice: unsupported MODE %0d", MODE);
        assign o_dn_valid = 1'b0;
        assign o_dn_data  = '0;
        assign o_up_ready = 1'b0;
    end

`ifdef VALID_READY_SLICE_BEATS_EN
    logic [BEATS_W-1:0] beats_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beats_q <= '0;
        end else if (o_dn_valid && i_dn_ready) begin
            beats_q <= beats_q + 1'b1;
        end
    end

    assign o_beats = beats_q;
`endif

endmodule

// File: tb/tb_valid_ready_slice.sv
// Bench for valid_ready_slice: one instance per MODE (bypass, forward, skid) sharing clk/rst.
// Upstream transfers push expected beats into per-instance queues; downstream beats are
// compared against the queue head.
module tb_valid_ready_slice;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       b_up_valid = 1'b0, b_up_ready, b_dn_valid, b_dn_ready = 1'b0;
    logic [7:0] b_up_data = 8'h00, b_dn_data;
    logic       f_up_valid = 1'b0, f_up_ready, f_dn_valid, f_dn_ready = 1'b0;
    logic [7:0] f_up_data = 8'h00, f_dn_data;
    logic       s_up_valid = 1'b0, s_up_ready, s_dn_valid, s_dn_ready = 1'b0;
    logic [7:0] s_up_data = 8'h00, s_dn_data;
`ifdef VALID_READY_SLICE_BEATS_EN
    logic [15:0] b_beats, f_beats, s_beats;
`endif

    logic [7:0] q_fwd[$];
    logic [7:0] q_skid[$];

    valid_ready_slice #(.WIDTH(8), .MODE(0)) u_byp (
        .clk(clk), .rst(rst), .i_up_valid(b_up_valid), .i_up_data(b_up_data),
        .o_up_ready(b_up_ready), .o_dn_valid(b_dn_valid), .o_dn_data(b_dn_data),
        .i_dn_ready(b_dn_ready)
`ifdef VALID_READY_SLICE_BEATS_EN
        , .o_beats(b_beats)
`endif
    );

    valid_ready_slice #(.WIDTH(8), .MODE(1)) u_fwd (
        .clk(clk), .rst(rst), .i_up_valid(f_up_valid), .i_up_data(f_up_data),
        .o_up_ready(f_up_ready), .o_dn_valid(f_dn_valid), .o_dn_data(f_dn_data),
        .i_dn_ready(f_dn_ready)
`ifdef VALID_READY_SLICE_BEATS_EN
        , .o_beats(f_beats)
`endif
    );

    valid_ready_slice #(.WIDTH(8), .MODE(2)) u_skid (
        .clk(clk), .rst(rst), .i_up_valid(s_up_valid), .i_up_data(s_up_data),
        .o_up_ready(s_up_ready), .o_dn_valid(s_dn_valid), .o_dn_data(s_dn_data),
        .i_dn_ready(s_dn_ready)
`ifdef VALID_READY_SLICE_BEATS_EN
        , .o_beats(s_beats)
`endif
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (f_dn_valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid: got %b want 0", f_dn_valid); end
        checks++; if (f_dn_data !== 8'h00) begin errors++; $display("FAIL reset_fwd_data: got %h want 00", f_dn_data); end
        checks++; if (f_up_ready !== 1'b1) begin errors++; $display("FAIL reset_fwd_ready: got %b want 1", f_up_ready); end
        checks++; if (s_dn_valid !== 1'b0) begin errors++; $display("FAIL reset_skid_valid: got %b want 0", s_dn_valid); end
        checks++; if (s_dn_data !== 8'h00) begin errors++; $display("FAIL reset_skid_data: got %h want 00", s_dn_data); end
        checks++; if (s_up_ready !== 1'b1) begin errors++; $display("FAIL reset_skid_ready: got %b want 1", s_up_ready); end
`ifdef VALID_READY_SLICE_BEATS_EN
        checks++; if (b_beats !== 16'h0) begin errors++; $display("FAIL reset_byp_beats: got %h want 0000", b_beats); end
        checks++; if (f_beats !== 16'h0) begin errors++; $display("FAIL reset_fwd_beats: got %h want 0000", f_beats); end
        checks++; if (s_beats !== 16'h0) begin errors++; $display("FAIL reset_skid_beats: got %h want 0000", s_beats); end
`endif
        rst = 1'b0;
        q_fwd.delete();
        q_skid.delete();
    endtask

    task automatic test_bypass();
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            b_up_valid = (i % 3) != 0;
            b_up_data  = 8'($urandom_range(0, 255));
            b_dn_ready = i[0];
            #1;
            checks++; if (b_up_ready !== b_dn_ready) begin errors++; $display("FAIL byp_ready[%0d]: got %b want %b", i, b_up_ready, b_dn_ready); end
            checks++; if (b_dn_valid !== b_up_valid) begin errors++; $display("FAIL byp_valid[%0d]: got %b want %b", i, b_dn_valid, b_up_valid); end
            checks++; if (b_dn_data !== b_up_data) begin errors++; $display("FAIL byp_data[%0d]: got %h want %h", i, b_dn_data, b_up_data); end
        end
        @(posedge clk); #1;
        b_up_valid = 1'b0;
        b_dn_ready = 1'b0;
    endtask

    task automatic test_fwd_back_to_back();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] exp;
        logic       exp_v;
        int         nvalid = 0;
        f_dn_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            f_up_valid = (c < 3);
            f_up_data  = (c < 3) ? vals[c] : 8'h00;
            @(negedge clk);
            exp_v = (c >= 1) && (c <= 3);
            checks++; if (f_dn_valid !== exp_v) begin errors++; $display("FAIL fwd_valid[%0d]: got %b want %b", c, f_dn_valid, exp_v); end
            checks++; if (f_up_ready !== 1'b1) begin errors++; $display("FAIL fwd_ready[%0d]: got %b want 1", c, f_up_ready); end
            if (f_dn_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (q_fwd.size() == 0) begin
                    errors++; $display("FAIL fwd_data[%0d]: got %h want no beat", c, f_dn_data);
                end else begin
                    exp = q_fwd.pop_front();
                    if (f_dn_data !== exp) begin errors++; $display("FAIL fwd_data[%0d]: got %h want %h", c, f_dn_data, exp); end
                end
            end
            if (f_up_valid && f_up_ready) q_fwd.push_back(f_up_data);
        end
        checks++; if (nvalid != 3) begin errors++; $display("FAIL fwd_valid_cycles: got %0d want 3", nvalid); end
        checks++; if (q_fwd.size() != 0) begin errors++; $display("FAIL fwd_leftover: got %0d want 0", q_fwd.size()); end
        f_dn_ready = 1'b0;
    endtask

    // Skid scenarios: fill to FULL then drain (cycles 0-5), then simultaneous up+down in BUSY.
    task automatic test_skid_backpressure();
        logic       up_v  [11] = '{1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0};
        logic [7:0] up_d  [11] = '{8'hA5, 8'h5A, 0, 0, 0, 0, 8'h01, 8'h07, 0, 0, 0};
        logic       dn_r  [11] = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0};
        logic       exp_r [11] = '{1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
        logic       exp_v [11] = '{0, 1, 1, 1, 1, 0, 0, 1, 1, 1, 0};
        logic [7:0] exp;
        for (int c = 0; c < 11; c++) begin
            @(posedge clk); #1;
            s_up_valid = up_v[c];
            s_up_data  = up_d[c];
            s_dn_ready = dn_r[c];
            @(negedge clk);
            checks++; if (s_up_ready !== exp_r[c]) begin errors++; $display("FAIL skid_ready[%0d]: got %b want %b", c, s_up_ready, exp_r[c]); end
            checks++; if (s_dn_valid !== exp_v[c]) begin errors++; $display("FAIL skid_valid[%0d]: got %b want %b", c, s_dn_valid, exp_v[c]); end
            if (s_dn_valid === 1'b1) begin
                checks++;
                if (q_skid.size() == 0) begin
                    errors++; $display("FAIL skid_data[%0d]: got %h want no beat", c, s_dn_data);
                end else begin
                    exp = q_skid[0];
                    if (s_dn_data !== exp) begin errors++; $display("FAIL skid_data[%0d]: got %h want %h", c, s_dn_data, exp); end
                    if (s_dn_ready) void'(q_skid.pop_front());
                end
            end
            if (s_up_valid && s_up_ready) q_skid.push_back(s_up_data);
        end
        checks++; if (q_skid.size() != 0) begin errors++; $display("FAIL skid_leftover: got %0d want 0", q_skid.size()); end
        s_dn_ready = 1'b0;
    endtask

    task automatic test_reset_while_full();
        @(posedge clk); #1;
        s_up_valid = 1'b1; s_up_data = 8'h3C; s_dn_ready = 1'b0;
        f_up_valid = 1'b1; f_up_data = 8'h99; f_dn_ready = 1'b0;
        @(posedge clk); #1;
        s_up_data = 8'hC3;
        f_up_valid = 1'b0;
        @(posedge clk); #1;
        s_up_valid = 1'b0;
        @(negedge clk);
        checks++; if (s_up_ready !== 1'b0) begin errors++; $display("FAIL rst_pre_skid_full: got ready %b want 0", s_up_ready); end
        checks++; if (s_dn_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_skid_valid: got %b want 1", s_dn_valid); end
        checks++; if (f_dn_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_fwd_valid: got %b want 1", f_dn_valid); end
        // Reset with concurrent upstream and downstream activity: reset must win.
        @(posedge clk); #1;
        rst = 1'b1;
        s_up_valid = 1'b1; s_up_data = 8'hEE; s_dn_ready = 1'b1;
        f_up_valid = 1'b1; f_up_data = 8'h77; f_dn_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        s_up_valid = 1'b0;
        f_up_valid = 1'b0;
        @(negedge clk);
        checks++; if (s_dn_data !== 8'h00) begin errors++; $display("FAIL rst_skid_data: got %h want 00", s_dn_data); end
        checks++; if (f_dn_data !== 8'h00) begin errors++; $display("FAIL rst_fwd_data: got %h want 00", f_dn_data); end
        checks++; if (s_up_ready !== 1'b1) begin errors++; $display("FAIL rst_skid_ready: got %b want 1", s_up_ready); end
        for (int c = 0; c < 4; c++) begin
            checks++; if (s_dn_valid !== 1'b0) begin errors++; $display("FAIL rst_skid_valid[%0d]: got %b want 0", c, s_dn_valid); end
            checks++; if (f_dn_valid !== 1'b0) begin errors++; $display("FAIL rst_fwd_valid[%0d]: got %b want 0", c, f_dn_valid); end
            @(negedge clk);
        end
        s_dn_ready = 1'b0;
        f_dn_ready = 1'b0;
        q_skid.delete();
        q_fwd.delete();
    endtask

`ifdef VALID_READY_SLICE_BEATS_EN
    task automatic test_beats_wrap();
        logic [15:0] exp_b [3] = '{16'hFFFF, 16'h0000, 16'h0001};
        @(posedge clk); #1;
        rst = 1'b1;
        b_up_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (b_beats !== 16'h0000) begin errors++; $display("FAIL beats_start: got %h want 0000", b_beats); end
        b_up_valid = 1'b1; b_up_data = 8'h5C; b_dn_ready = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        checks++; if (b_beats !== 16'hFFFE) begin errors++; $display("FAIL beats_preload: got %h want FFFE", b_beats); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++; if (b_beats !== exp_b[i]) begin errors++; $display("FAIL beats_wrap[%0d]: got %h want %h", i, b_beats, exp_b[i]); end
        end
        b_up_valid = 1'b0;
        b_dn_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_bypass();
        test_fwd_back_to_back();
        test_skid_backpressure();
        test_reset_while_full();
`ifdef VALID_READY_SLICE_BEATS_EN
        test_beats_wrap();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
